pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage rv32i pipeline. It drives the enable (stall) and

---
 rtl/pipe_hazard_ctrl_pkg.sv | 55 +++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the rv32i pipeline stall/flush controller.
// Holds the FSM state encoding, the x0 register constant and the per-register control bundle.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic memwb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NONE = '0;

  // Freeze everything up to EX/MEM and push a bubble into WB.
  function automatic pipe_ctrl_t ctrl_freeze();
    pipe_ctrl_t c;
    c             = CTRL_NONE;
    c.pc_stall    = 1'b1;
    c.ifid_stall  = 1'b1;
    c.idex_stall  = 1'b1;
    c.exmem_stall = 1'b1;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

  function automatic pipe_ctrl_t ctrl_branch();
    pipe_ctrl_t c;
    c            = CTRL_NONE;
    c.ifid_flush = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  function automatic pipe_ctrl_t ctrl_bubble();
    pipe_ctrl_t c;
    c            = CTRL_NONE;
    c.pc_stall   = 1'b1;
    c.ifid_stall = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Pure combinational load-use compare between the load in EX and the sources read in ID.
// Also used by the forwarding unit, so it carries no state and no reset.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             idex_mem_read_i,
  input  logic [REG_W-1:0] idex_rd_i,
  output logic             load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1_i && (id_rs1_i == idex_rd_i);
  assign rs2_hit = id_use_rs2_i && (id_rs2_i == idex_rd_i);

  // x0 is hard-wired zero, so a load targeting it never produces a dependency.
  assign load_use_o = idex_mem_read_i && (idex_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory wait FSM with timeout,
// priority mux of pipe-register controls and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNTW        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             idex_mem_read_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic             ex_br_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_flush_o,
  output logic             exmem_stall_o,
  output logic             memwb_flush_o,
  output logic             mem_err_o,
  output logic [CNTW-1:0]  stall_cnt_o
);

  localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;

  logic       load_use;
  logic       mem_stall;
  pipe_ctrl_t ctrl;

  hazard_detect u_hazard_detect (
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .id_use_rs1_i    (id_use_rs1_i),
    .id_use_rs2_i    (id_use_rs2_i),
    .idex_mem_read_i (idex_mem_read_i),
    .idex_rd_i       (idex_rd_i),
    .load_use_o      (load_use)
  );

  assign mem_stall = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) &&
                     mem_req_i && !mem_ack_i;

  // Controls are gated by reset so no flush or stall leaks out while held in reset.
  always_comb begin
    ctrl = CTRL_NONE;
    if (rst_i) begin
      ctrl = CTRL_NONE;
    end else if (state_q == ST_ERR) begin
      ctrl = ctrl_freeze();
    end else if (mem_stall) begin
      ctrl = ctrl_freeze();
    end else if (ex_br_taken_i) begin
      ctrl = ctrl_branch();
    end else if (load_use) begin
      ctrl = ctrl_bubble();
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        // A dropped request is an abort, not an error.
        if (!mem_req_i || mem_ack_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_ERR;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl.pc_stall && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_stall_o    = ctrl.pc_stall;
  assign ifid_stall_o  = ctrl.ifid_stall;
  assign ifid_flush_o  = ctrl.ifid_flush;
  assign idex_stall_o  = ctrl.idex_stall;
  assign idex_flush_o  = ctrl.idex_flush;
  assign exmem_stall_o = ctrl.exmem_stall;
  assign memwb_flush_o = ctrl.memwb_flush;
  assign mem_err_o     = (state_q == ST_ERR) && !rst_i;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int TO   = 16;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [4:0]    id_rs1_i, id_rs2_i, idex_rd_i;
  logic          id_use_rs1_i, id_use_rs2_i, idex_mem_read_i;
  logic          ex_br_taken_i, mem_req_i, mem_ack_i;
  logic          pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o;
  logic          exmem_stall_o, memwb_flush_o, mem_err_o;
  logic [CW-1:0] stall_cnt_o;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNTW(CW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .id_use_rs1_i    (id_use_rs1_i),
    .id_use_rs2_i    (id_use_rs2_i),
    .idex_mem_read_i (idex_mem_read_i),
    .idex_rd_i       (idex_rd_i),
    .ex_br_taken_i   (ex_br_taken_i),
    .mem_req_i       (mem_req_i),
    .mem_ack_i       (mem_ack_i),
    .pc_stall_o      (pc_stall_o),
    .ifid_stall_o    (ifid_stall_o),
    .ifid_flush_o    (ifid_flush_o),
    .idex_stall_o    (idex_stall_o),
    .idex_flush_o    (idex_flush_o),
    .exmem_stall_o   (exmem_stall_o),
    .memwb_flush_o   (memwb_flush_o),
    .mem_err_o       (mem_err_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush, mem_err}
  wire [7:0] obs_ctrl = {pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
                         idex_flush_o, exmem_stall_o, memwb_flush_o, mem_err_o};

  localparam logic [7:0] EXP_ERR    = 8'b1101_0111;
  localparam logic [7:0] EXP_FREEZE = 8'b1101_0110;
  localparam logic [7:0] EXP_BRANCH = 8'b0010_1000;
  localparam logic [7:0] EXP_BUBBLE = 8'b1100_1000;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: error flag, waiting flag, number of consecutive waiting cycles, stall total.
  bit m_err;
  bit m_wait;
  int m_wlen;
  int m_scnt;
  int saved;

  function automatic logic [7:0] exp_ctrl();
    bit lu, ms;
    lu = idex_mem_read_i && (idex_rd_i != 0) &&
         ((id_use_rs1_i && id_rs1_i == idex_rd_i) || (id_use_rs2_i && id_rs2_i == idex_rd_i));
    ms = !m_err && mem_req_i && !mem_ack_i;
    if (rst_i)         return 8'h00;
    if (m_err)         return EXP_ERR;
    if (ms)            return EXP_FREEZE;
    if (ex_br_taken_i) return EXP_BRANCH;
    if (lu)            return EXP_BUBBLE;
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_err  = 0;
    m_wait = 0;
    m_wlen = 0;
    m_scnt = 0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step(input string tag);
    logic [7:0] e;
    #1;
    e = exp_ctrl();
    chk({tag, ".ctrl"}, 64'(obs_ctrl), 64'(e));
    chk({tag, ".cnt"}, 64'(stall_cnt_o), 64'(m_scnt));
    if (e[7] && m_scnt < CMAX) m_scnt++;
    if (!m_err) begin
      if (!m_wait) begin
        if (mem_req_i && !mem_ack_i) begin
          m_wait = 1;
          m_wlen = 1;
        end
      end else if (!mem_req_i || mem_ack_i) begin
        m_wait = 0;
      end else if (m_wlen == TO - 1) begin
        m_err  = 1;
        m_wait = 0;
      end else begin
        m_wlen++;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic reset_dut(input string tag);
    #2;
    rst_i = 1'b1;
    #1;
    chk({tag, ".rst_ctrl"}, 64'(obs_ctrl), 64'h0);
    chk({tag, ".rst_cnt"}, 64'(stall_cnt_o), 64'h0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic idle();
    id_rs1_i        = 0;
    id_rs2_i        = 0;
    id_use_rs1_i    = 0;
    id_use_rs2_i    = 0;
    idex_mem_read_i = 0;
    idex_rd_i       = 0;
    ex_br_taken_i   = 0;
    mem_req_i       = 0;
    mem_ack_i       = 0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    model_reset();
    @(negedge clk_i);
    reset_dut("init");
    step("init_idle");

    // Load-use on rs1: one bubble, then clear once the load leaves EX.
    idex_mem_read_i = 1; idex_rd_i = 5; id_rs1_i = 5; id_use_rs1_i = 1;
    #1 chk("t1_bubble", 64'(obs_ctrl), 64'(EXP_BUBBLE));
    step("t1_bubble");
    idex_mem_read_i = 0;
    step("t1_after");

    // x0 destination and unused source never stall.
    saved = m_scnt;
    idex_mem_read_i = 1; idex_rd_i = 0; id_rs1_i = 0; id_use_rs1_i = 1;
    step("t2_x0");
    idex_rd_i = 5; id_rs1_i = 5; id_use_rs1_i = 0; id_rs2_i = 5; id_use_rs2_i = 0;
    step("t2_nouse");
    chk("t2_cnt", 64'(stall_cnt_o), 64'(saved));

    // Taken branch beats load-use.
    id_use_rs2_i = 1;
    ex_br_taken_i = 1;
    #1 chk("t3_branch", 64'(obs_ctrl), 64'(EXP_BRANCH));
    step("t3_branch");
    idle();

    // Three wait cycles with a branch frozen in EX, flushed on the ack cycle.
    saved = m_scnt;
    mem_req_i = 1; mem_ack_i = 0; ex_br_taken_i = 1;
    repeat (3) step("t4_wait");
    mem_ack_i = 1;
    #1 chk("t4_ack", 64'(obs_ctrl), 64'(EXP_BRANCH));
    step("t4_ack");
    idle();
    step("t4_idle");
    chk("t4_cnt", 64'(stall_cnt_o), 64'(saved + 3));

    // Timeout: ERR after exactly 16 stalled cycles, sticky, cleared by async reset.
    mem_req_i = 1; mem_ack_i = 0;
    repeat (TO - 1) step("t5_wait");
    chk("t5_not_yet", 64'(mem_err_o), 64'h0);
    step("t5_last");
    chk("t5_err", 64'(mem_err_o), 64'h1);
    mem_req_i = 0;
    repeat (3) step("t5_hold");
    chk("t5_sticky", 64'(mem_err_o), 64'h1);
    mem_req_i = 1;
    reset_dut("t5");
    step("t5_post_rst");
    idle();
    reset_dut("t5b");

    // Saturation: stall long enough to pass the counter maximum.
    mem_req_i = 1; mem_ack_i = 0;
    repeat (TO + 20) step("t6_sat");
    chk("t6_sat_cnt", 64'(stall_cnt_o), 64'(CMAX));
    idle();
    reset_dut("t6");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset_dut("rand");
      end else begin
        id_rs1_i        = 5'($urandom_range(0, 3));
        id_rs2_i        = 5'($urandom_range(0, 3));
        idex_rd_i       = 5'($urandom_range(0, 3));
        id_use_rs1_i    = 1'($urandom_range(0, 1));
        id_use_rs2_i    = 1'($urandom_range(0, 1));
        idex_mem_read_i = 1'($urandom_range(0, 1));
        ex_br_taken_i   = ($urandom_range(0, 3) == 0);
        mem_req_i       = ($urandom_range(0, 3) != 0);
        mem_ack_i       = ($urandom_range(0, 2) == 0);
        step("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
